// File: rtl/pla_equiv_sweeper_pkg.sv
// Shared types and constants for the PLA equivalence sweeper.
// The state enum is also exported on the top level as a debug output.
package pla_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    localparam int LAT_MAX = 8;

    // One extra bit so a full 2^n sweep count never wraps.
    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/pla_equiv_sweeper_if.sv
// Vector bus between the sweeper and the two netlists under test.
interface pla_equiv_sweeper_if #(
    parameter int N_IN = 21
);
    // vec_valid qualifies vec_out in the cycle it is high. There is no ready:
    // the netlists accept a vector every cycle and return y_a/y_b exactly LAT
    // cycles later, so responses are matched by position, not by handshake.
    logic [N_IN-1:0] vec_out;
    logic            vec_valid;
    logic            y_a;
    logic            y_b;

    modport master (output vec_out, output vec_valid, input y_a, input y_b);
    modport slave  (input vec_out, input vec_valid, output y_a, output y_b);
endinterface

// File: rtl/pla_equiv_sweeper_tagpipe.sv
// Delay line carrying (valid, vector) tags alongside the netlist latency.
// LAT=0 degenerates to wires.
module pla_sweep_tagpipe #(
    parameter int N_IN = 21,
    parameter int LAT  = 1
) (
    input  logic            i_clk,
    input  logic            i_flush,
    input  logic            i_valid,
    input  logic [N_IN-1:0] i_vec,
    output logic            o_valid,
    output logic [N_IN-1:0] o_vec,
    output logic            o_pending
);

    if (LAT == 0) begin : g_wire
        logic w_unused;
        assign w_unused  = &{1'b0, i_clk, i_flush};
        assign o_valid   = i_valid;
        assign o_vec     = i_vec;
        assign o_pending = 1'b0;
    end else begin : g_pipe
        logic [LAT-1:0]  r_valid;
        logic [N_IN-1:0] r_vec [LAT];
        logic [LAT-1:0]  w_lower;

        always_ff @(posedge i_clk) begin
            if (i_flush) begin
                r_valid <= '0;
            end else begin
                r_valid[0] <= i_valid;
                for (int i = 1; i < LAT; i++) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
            r_vec[0] <= i_vec;
            for (int i = 1; i < LAT; i++) begin
                r_vec[i] <= r_vec[i-1];
            end
        end

        // Pending = a tag still upstream of the output stage after this cycle.
        assign w_lower   = r_valid << 1;
        assign o_pending = i_valid | (|w_lower);
        assign o_valid   = r_valid[LAT-1];
        assign o_vec     = r_vec[LAT-1];
    end

endmodule

// File: rtl/pla_equiv_sweeper.sv
// Sweeps every input vector into two netlists, compares their outputs after
// LAT cycles and records the mismatch count and the first failing vector.
module pla_equiv_sweeper
    import pla_sweep_pkg::*;
#(
    parameter int N_IN = 21,
    parameter int LAT  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_pause,
    input  logic                 i_stop_on_fail,
    pla_equiv_sweeper_if.master  bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_aborted,
    output logic [N_IN:0]        o_mismatch_cnt,
    output logic [N_IN:0]        o_checked_cnt,
    output logic [N_IN-1:0]      o_first_fail_vec,
    output logic                 o_first_fail_valid,
    output sweep_state_t         o_state
);

    localparam int CW = cnt_width(N_IN);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = {1'b0, {N_IN{1'b1}}};

    sweep_state_t    r_state, w_next;
    logic [CW-1:0]   r_issue, r_mis, r_chk;
    logic [N_IN-1:0] r_ffvec;
    logic            r_ffv, r_aborted, r_stop;

    logic            w_start_ok, w_abort, w_vec_valid, w_last;
    logic            w_cmp_valid, w_fail, w_stop_hit, w_stopping, w_pending;
    logic [N_IN-1:0] w_cmp_vec;

    assign w_start_ok  = (r_state == IDLE) & i_start & ~i_abort;
    assign w_abort     = i_abort & (r_state != IDLE);
    assign w_vec_valid = (r_state == SWEEP) & ~i_pause & ~w_stopping;
    assign w_last      = w_vec_valid & (r_issue == LAST);
    assign w_fail      = w_cmp_valid & (bus.y_a ^ bus.y_b);
    assign w_stop_hit  = w_fail & r_stop & (r_state == SWEEP);

    // With LAT=0 the failing vector is the one issuing now, so leaving SWEEP
    // at the edge is enough; suppressing it would also break the comb path.
    if (LAT == 0) begin : g_stop_comb
        assign w_stopping = 1'b0;
    end else begin : g_stop_pipe
        assign w_stopping = w_stop_hit;
    end

    pla_sweep_tagpipe #(.N_IN(N_IN), .LAT(LAT)) u_tagpipe (
        .i_clk     (i_clk),
        .i_flush   (i_rst | w_abort),
        .i_valid   (w_vec_valid),
        .i_vec     (r_issue[N_IN-1:0]),
        .o_valid   (w_cmp_valid),
        .o_vec     (w_cmp_vec),
        .o_pending (w_pending)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start_ok) w_next = SWEEP;
            SWEEP:   if (w_last || w_stop_hit) w_next = (LAT == 0) ? DONE : DRAIN;
            DRAIN:   if (!w_pending) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_issue   <= '0;
            r_mis     <= '0;
            r_chk     <= '0;
            r_ffvec   <= '0;
            r_ffv     <= 1'b0;
            r_aborted <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_issue   <= '0;
                r_mis     <= '0;
                r_chk     <= '0;
                r_ffvec   <= '0;
                r_ffv     <= 1'b0;
                r_aborted <= 1'b0;
                r_stop    <= i_stop_on_fail;
            end else if (w_abort) begin
                // Partial counts are kept; the abort-cycle compare is dropped.
                r_aborted <= 1'b1;
            end else begin
                if (w_vec_valid) r_issue <= r_issue + ONE;
                if (w_cmp_valid) begin
                    r_chk <= r_chk + ONE;
                    if (w_fail) begin
                        r_mis <= r_mis + ONE;
                        if (!r_ffv) begin
                            r_ffv   <= 1'b1;
                            r_ffvec <= w_cmp_vec;
                        end
                    end
                end
            end
        end
    end

    assign bus.vec_out         = r_issue[N_IN-1:0];
    assign bus.vec_valid       = w_vec_valid;
    assign o_busy              = (r_state != IDLE);
    assign o_done              = (r_state == DONE);
    assign o_aborted           = r_aborted;
    assign o_mismatch_cnt      = r_mis;
    assign o_checked_cnt       = r_chk;
    assign o_first_fail_vec    = r_ffvec;
    assign o_first_fail_valid  = r_ffv;
    assign o_state             = r_state;

endmodule

// File: tb/tb_pla_equiv_sweeper.sv
// Bench: three sweepers (N_IN=4, LAT=0/1/2) share control stimulus; each has
// its own netlist model, reference model, expected queues and monitor.
module tb_pla_equiv_sweeper;
    import pla_sweep_pkg::*;

    localparam int NI   = 4;
    localparam int WIN  = 40;
    localparam int NONE = 999;

    typedef struct {
        int done_rel;
        int n_chk;
        int n_mis;
        bit ffv;
        int ffvec;
    } res_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, pause, stop_on_fail, zchk;
    int          cyc = 0;
    int          s0 = -100000;
    bit          pmap [64];
    logic [15:0] mis_mask;
    bit          stop_f;
    int          abort_at = NONE;
    int          rst_at = NONE;
    int          errors = 0;
    int          checks = 0;
    event        run_ev, end_ev;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int lat, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s lat=%0d got=%0d want=%0d (cycle %0d)", name, lat, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int L = g;

        pla_equiv_sweeper_if #(.N_IN(NI)) bus ();
        logic            busy, done, aborted, ffv;
        logic [NI:0]     mis_cnt, chk_cnt;
        logic [NI-1:0]   ffvec, vec_d;
        sweep_state_t    st;
        logic [NI-1:0]   hist [3];
        logic [NI-1:0]   exp_vec_q [$];
        res_t            exp_res_q [$];
        int              exp_abort_chk;

        pla_equiv_sweeper #(.N_IN(NI), .LAT(L)) dut (
            .i_clk              (clk),
            .i_rst              (rst),
            .i_start            (start),
            .i_abort            (abort),
            .i_pause            (pause),
            .i_stop_on_fail     (stop_on_fail),
            .bus                (bus),
            .o_busy             (busy),
            .o_done             (done),
            .o_aborted          (aborted),
            .o_mismatch_cnt     (mis_cnt),
            .o_checked_cnt      (chk_cnt),
            .o_first_fail_vec   (ffvec),
            .o_first_fail_valid (ffv),
            .o_state            (st)
        );

        // Netlist pair: reference is XOR of inputs; the rewrite flips the
        // result wherever mis_mask has a bit set. Both see LAT cycles of delay.
        always @(posedge clk) begin
            hist[0] <= bus.vec_out;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
        if (L == 0) begin : g_d0
            assign vec_d = bus.vec_out;
        end else begin : g_dn
            assign vec_d = hist[L-1];
        end
        assign bus.y_a = ^vec_d;
        assign bus.y_b = (^vec_d) ^ mis_mask[vec_d];

        // Reference model: walk issue cycles from the pause map and derive
        // what every vector, counter and the done cycle must be.
        always @(run_ev) begin
            int c, k, lim, cut, t_exit, c_last, n_chk, n_mis, ff, dn;
            bit ffv_m, stop_set;
            res_t r;
            exp_vec_q.delete();
            exp_res_q.delete();
            c = 1; k = 0; lim = NONE; t_exit = -1; c_last = 0;
            n_chk = 0; n_mis = 0; ff = 0; ffv_m = 0; stop_set = 0;
            cut = (abort_at < rst_at) ? abort_at : rst_at;
            while (k < 16 && c <= lim && c <= cut) begin
                if (!pmap[c]) begin
                    exp_vec_q.push_back(k[NI-1:0]);
                    c_last = c;
                    if (c + L < abort_at) begin
                        n_chk++;
                        if (mis_mask[k]) begin
                            n_mis++;
                            if (!ffv_m) begin ffv_m = 1; ff = k; end
                        end
                    end
                    if (stop_f && mis_mask[k] && !stop_set) begin
                        stop_set = 1;
                        lim = c + ((L == 0) ? 0 : L - 1);
                        t_exit = c + L;
                    end
                    if (k == 15 && (t_exit < 0 || c < t_exit)) t_exit = c;
                    k++;
                end
                c++;
            end
            exp_abort_chk = n_chk;
            if (t_exit >= 0) begin
                if (L == 0) dn = t_exit + 1;
                else dn = (t_exit + 2 > c_last + L + 1) ? t_exit + 2 : c_last + L + 1;
                if (dn < abort_at && dn <= rst_at) begin
                    r.done_rel = dn; r.n_chk = n_chk; r.n_mis = n_mis;
                    r.ffv = ffv_m; r.ffvec = ff;
                    exp_res_q.push_back(r);
                end
            end
        end

        always @(negedge clk) begin
            int rel;
            res_t r;
            logic [NI-1:0] e;
            rel = cyc - s0;
            if (bus.vec_valid) begin
                if (exp_vec_q.size() == 0) begin
                    check("vec_extra", L, bus.vec_out, -1);
                end else begin
                    e = exp_vec_q.pop_front();
                    check("vec_out", L, bus.vec_out, e);
                end
            end
            if (done) begin
                if (exp_res_q.size() == 0) begin
                    check("done_unexpected", L, rel, -1);
                end else begin
                    r = exp_res_q.pop_front();
                    check("done_cycle", L, rel, r.done_rel);
                    check("checked_cnt", L, chk_cnt, r.n_chk);
                    check("mismatch_cnt", L, mis_cnt, r.n_mis);
                    check("first_fail_valid", L, ffv, r.ffv);
                    if (r.ffv) check("first_fail_vec", L, ffvec, r.ffvec);
                    check("vec_skipped", L, exp_vec_q.size(), 0);
                end
            end
            if (rel == 1) begin
                check("start_busy", L, busy, 1);
                check("start_aborted", L, aborted, 0);
                check("start_checked", L, chk_cnt, 0);
                check("start_mismatch", L, mis_cnt, 0);
                check("start_ffv", L, ffv, 0);
            end
            if (rel == abort_at + 1) begin
                check("abort_busy", L, busy, 0);
                check("abort_state", L, st, IDLE);
                check("abort_sticky", L, aborted, 1);
                check("abort_partial", L, chk_cnt, exp_abort_chk);
            end
            if (zchk) begin
                check("rst_vec_out", L, bus.vec_out, 0);
                check("rst_vec_valid", L, bus.vec_valid, 0);
                check("rst_busy", L, busy, 0);
                check("rst_done", L, done, 0);
                check("rst_aborted", L, aborted, 0);
                check("rst_mismatch", L, mis_cnt, 0);
                check("rst_checked", L, chk_cnt, 0);
                check("rst_ffvec", L, ffvec, 0);
                check("rst_ffv", L, ffv, 0);
            end
        end

        // A run window that closes with expectations left means a missing
        // done or missing vectors: the DUT stalled or ended early.
        always @(end_ev) begin
            check("run_results_left", L, exp_res_q.size(), 0);
            check("run_vectors_left", L, exp_vec_q.size(), 0);
        end
    end

    task automatic do_run(input logic [15:0] mask, input bit stop, input int p_at,
                          input int p_len, input int ab, input int rs);
        mis_mask = mask;
        stop_f   = stop;
        abort_at = ab;
        rst_at   = rs;
        for (int i = 0; i < 64; i++) pmap[i] = (i >= p_at) && (i < p_at + p_len);
        @(posedge clk); #1;
        s0 = cyc;
        ->run_ev;
        for (int r = 0; r < WIN; r++) begin
            start        = (r == 0);
            stop_on_fail = stop;
            pause        = pmap[r];
            abort        = (r == ab);
            rst          = (r == rs);
            zchk         = (r == rs + 1);
            @(posedge clk); #1;
        end
        start = 0; pause = 0; abort = 0; rst = 0; zchk = 0;
        ->end_ev;
        abort_at = NONE;
        rst_at   = NONE;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; pause = 0; stop_on_fail = 0; zchk = 0;
        mis_mask = '0; stop_f = 0;
        repeat (3) @(posedge clk);
        #1 zchk = 1;
        @(posedge clk); #1;
        zchk = 0; rst = 0;

        do_run(16'h0000, 0, 0, 0, NONE, NONE);
        do_run(16'h1020, 0, 0, 0, NONE, NONE);
        do_run(16'h1020, 1, 0, 0, NONE, NONE);
        do_run(16'h0000, 0, 8, 3, NONE, NONE);
        do_run(16'h0000, 0, 0, 0, 6, NONE);
        do_run(16'h0000, 0, 0, 0, NONE, NONE);
        do_run(16'h0000, 0, 0, 0, NONE, 17);
        do_run(16'h0000, 0, 0, 0, NONE, NONE);
        for (int n = 0; n < 10; n++) begin
            logic [15:0] m;
            m = 16'($urandom) & 16'($urandom);
            do_run(m, 1'($urandom_range(0, 1)), $urandom_range(3, 14),
                   $urandom_range(0, 4), NONE, NONE);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
